// File: rtl/ram512_pkg.sv
// Shared constants and types for the ram512 data-memory tree.
package ram_pkg;
  localparam int WORD_W       = 16;
  typedef logic [WORD_W-1:0] word_t;
  localparam int RAM64_ADDR_W = 6;
  localparam int RAM512_BANKS = 8;
endpackage

// File: rtl/ram512_ram64.sv
// 64-word flip-flop RAM bank: synchronous write/reset, combinational read.
module ram64
  import ram_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        in,
  input  logic [RAM64_ADDR_W-1:0] add,
  input  logic                    load,
  output logic [WIDTH-1:0]        o
);
  localparam int DEPTH = 1 << RAM64_ADDR_W;

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Reset wins over load so a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (load) begin
      r_mem[add] <= in;
    end
  end

  assign o = r_mem[add];
endmodule

// File: rtl/ram512.sv
// 512x16 flip-flop RAM built from eight ram64 banks selected by add[8:6].
// Define RAM512_OUT_REG_EN for a registered (read-first, 1-cycle) output.
module ram512
  import ram_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] add,
  input  logic              load,
  output logic [WIDTH-1:0]  o
);
  localparam int BSEL_W = ADDR_W - RAM64_ADDR_W;

  logic [BSEL_W-1:0]       w_bsel;
  logic [RAM512_BANKS-1:0] w_load;
  logic [WIDTH-1:0]        w_bank_o [RAM512_BANKS];
  logic [WIDTH-1:0]        w_rd;

  assign w_bsel = add[ADDR_W-1:RAM64_ADDR_W];

  for (genvar b = 0; b < RAM512_BANKS; b++) begin : g_bank
    assign w_load[b] = load && (w_bsel == BSEL_W'(b));

    ram64 #(.WIDTH(WIDTH)) u_ram64 (
      .clk  (clk),
      .rst  (rst),
      .in   (in),
      .add  (add[RAM64_ADDR_W-1:0]),
      .load (w_load[b]),
      .o    (w_bank_o[b])
    );
  end

  assign w_rd = w_bank_o[w_bsel];

`ifdef RAM512_OUT_REG_EN
  logic [WIDTH-1:0] r_o;

  // Samples the array before the same-edge write lands: read-first.
  always_ff @(posedge clk) begin
    if (rst) r_o <= '0;
    else     r_o <= w_rd;
  end

  assign o = r_o;
`else
  assign o = w_rd;
`endif
endmodule

// File: tb/tb_ram512.sv
// Randomized self-checking bench for ram512 against an array reference model.
module tb_ram512;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] in  = '0;
  logic [8:0]  add = '0;
  logic        load = 1'b0;
  logic [15:0] o;

  logic [15:0] model [512];
  int n_chk = 0;
  int n_err = 0;

  ram512 dut (
    .clk  (clk),
    .rst  (rst),
    .in   (in),
    .add  (add),
    .load (load),
    .o    (o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [8:0] a, input logic [15:0] d);
    @(negedge clk);
    add = a; in = d; load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    model[a] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; load = 1'b1; in = 16'h1234; add = 9'd5;
    @(posedge clk);
    #1 rst = 1'b0; load = 1'b0;
    for (int i = 0; i < 512; i++) model[i] = '0;
  endtask

  task automatic rd(input string tag, input logic [8:0] a);
    @(negedge clk);
    add = a; load = 1'b0;
`ifdef RAM512_OUT_REG_EN
    @(posedge clk);
`endif
    #1 chk($sformatf("%s[%0d]", tag, a), o, model[a]);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout got=running exp=done");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] a;
    logic [15:0] d;

    do_reset();
    rd("init_rst", 9'd0);

    // Reset clears everything and discards a coincident write to 5
    wr(9'd0, 16'hFFFF); wr(9'd63, 16'hFFFF); wr(9'd64, 16'hFFFF); wr(9'd511, 16'hFFFF);
    do_reset();
    rd("rst_clr", 9'd0);  rd("rst_clr", 9'd63); rd("rst_clr", 9'd64);
    rd("rst_clr", 9'd511); rd("rst_clr", 9'd5);

    // Basic write/read
    wr(9'd0, 16'd123); wr(9'd1, 16'd246);
    rd("basic", 9'd0); rd("basic", 9'd1);

    // Hold with load low
    @(negedge clk);
    add = 9'd0; in = 16'd999; load = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("hold_o", o, 16'd123);
    rd("hold", 9'd0); rd("hold", 9'd1); rd("hold", 9'd2);

    // Bank boundaries
    wr(9'd63, 16'h0A0A); wr(9'd64, 16'h0B0B); wr(9'd511, 16'hFFFF); wr(9'd448, 16'h1C0C);
    rd("bound", 9'd63); rd("bound", 9'd64); rd("bound", 9'd511); rd("bound", 9'd448);
    rd("bound", 9'd62); rd("bound", 9'd65); rd("bound", 9'd510); rd("bound", 9'd447);

    // Read-during-write at one address
    wr(9'd10, 16'd5);
    @(negedge clk);
    add = 9'd10; in = 16'd7; load = 1'b1;
`ifdef RAM512_OUT_REG_EN
    @(posedge clk);
    #1 load = 1'b0;
    chk("rdw_edge", o, 16'd5);
    @(posedge clk);
    #1 chk("rdw_next", o, 16'd7);
`else
    #1 chk("rdw_pre", o, 16'd5);
    @(posedge clk);
    #1 load = 1'b0;
    chk("rdw_post", o, 16'd7);
`endif
    model[10] = 16'd7;

    // Exhaustive sweep, then its inverse, to expose bank aliasing
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 512; i++) begin
        d = 16'((i * 123) % 65536);
        wr(9'(i), (p == 0) ? d : ~d);
      end
      for (int i = 0; i < 512; i++) rd(p == 0 ? "sweep" : "sweep_inv", 9'(i));
    end

    // Random mix of writes, reads and an occasional reset
    for (int k = 0; k < 600; k++) begin
      a = 9'($urandom_range(0, 511));
      d = 16'($urandom);
      case ($urandom_range(0, 19))
        0:               do_reset();
        1, 2, 3, 4, 5,
        6, 7, 8:         wr(a, d);
        default:         rd("rand", a);
      endcase
    end

    // Address changes alone must move the read (no clock in comb mode)
    for (int k = 0; k < 16; k++) rd("rand_rd", 9'($urandom_range(0, 511)));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
